// File: rtl/seq_det_pkg.sv
// rtl/seq_det_pkg.sv - shared state type and sizing helper for the sequence detector
package seq_det_pkg;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        FILLING = 2'd1,
        ARMED   = 2'd2
    } seq_state_t;

    function automatic int fill_width(input int len);
        return $clog2(len);
    endfunction

endpackage

// File: rtl/sym_shift_reg.sv
// rtl/sym_shift_reg.sv - enable-shifted symbol history, stage 0 oldest, flattened output
module sym_shift_reg #(
    parameter int W     = 2,
    parameter int DEPTH = 3
) (
    input  logic               clk_i,
    input  logic               clr_i,
    input  logic               en_i,
    input  logic [W-1:0]       sym_i,
    output logic [DEPTH*W-1:0] stages_o
);

    logic [DEPTH*W-1:0] stages_q;
    logic [DEPTH*W-1:0] stages_d;

    // Newest symbol enters the top stage; everything else moves one stage toward 0.
    generate
        if (DEPTH == 1) begin : g_single
            assign stages_d = sym_i;
        end else begin : g_multi
            assign stages_d = {sym_i, stages_q[DEPTH*W-1:W]};
        end
    endgenerate

    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            stages_q <= '0;
        end else if (en_i) begin
            stages_q <= stages_d;
        end
    end

    assign stages_o = stages_q;

endmodule

// File: rtl/seq_detector.sv
// rtl/seq_detector.sv - streaming programmable-pattern detector with saturating match counter
module seq_detector
    import seq_det_pkg::*;
#(
    parameter int W     = 2,
    parameter int LEN   = 4,
    parameter int CNT_W = 8
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               in_valid_i,
    input  logic [W-1:0]       in_sym_i,
    input  logic [LEN*W-1:0]   pat_i,
    input  logic               overlap_i,
    input  logic               clr_i,
    output logic               match_o,
    output logic [CNT_W-1:0]   match_cnt_o,
    output logic [1:0]         state_o
);

    localparam int             FW       = fill_width(LEN);
    localparam logic [FW-1:0]  FILL_MAX = FW'(LEN - 1);

    logic [(LEN-1)*W-1:0] hist;
    logic                 accept;
    logic                 hit;

    logic [FW-1:0]    fill_q, fill_d;
    seq_state_t       state_q, state_d;
    logic             match_q, match_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // A clear drops the symbol offered in the same cycle.
    assign accept = in_valid_i & ~clr_i;

    // History contents only matter once ARMED, so clr leaves them alone.
    sym_shift_reg #(
        .W     (W),
        .DEPTH (LEN - 1)
    ) u_hist (
        .clk_i    (clk_i),
        .clr_i    (rst_i),
        .en_i     (accept),
        .sym_i    (in_sym_i),
        .stages_o (hist)
    );

    assign hit = accept && (state_q == ARMED) && ({in_sym_i, hist} == pat_i);

    always_comb begin
        fill_d  = fill_q;
        match_d = 1'b0;
        cnt_d   = cnt_q;
        if (clr_i) begin
            fill_d = '0;
            cnt_d  = '0;
        end else if (accept) begin
            if (hit) begin
                match_d = 1'b1;
                if (cnt_q != '1) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                fill_d = overlap_i ? FILL_MAX : '0;
            end else if (fill_q != FILL_MAX) begin
                fill_d = fill_q + FW'(1);
            end
        end
        if (fill_d == '0) begin
            state_d = EMPTY;
        end else if (fill_d == FILL_MAX) begin
            state_d = ARMED;
        end else begin
            state_d = FILLING;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fill_q  <= '0;
            state_q <= EMPTY;
            match_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            fill_q  <= fill_d;
            state_q <= state_d;
            match_q <= match_d;
            cnt_q   <= cnt_d;
        end
    end

    assign match_o     = match_q;
    assign match_cnt_o = cnt_q;
    assign state_o     = state_q;

endmodule

// File: tb/tb_seq_detector.sv
// tb/tb_seq_detector.sv - scoreboard bench for seq_detector with directed vectors
module tb_seq_detector;

    localparam logic [1:0] E = 2'd0;
    localparam logic [1:0] F = 2'd1;
    localparam logic [1:0] A = 2'd2;
    localparam logic [5:0] PAT_123 = {2'd3, 2'd2, 2'd1};
    localparam logic [5:0] PAT_111 = {2'd1, 2'd1, 2'd1};

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rst_sat = 1'b1;
    logic       clr = 1'b0;
    logic       vld = 1'b0;
    logic [1:0] sym = 2'd0;
    logic [5:0] pat = PAT_123;
    logic       ovl = 1'b1;

    logic       m_match;
    logic [7:0] m_cnt;
    logic [1:0] m_state;
    logic       s_match;
    logic [1:0] s_cnt;
    logic [1:0] s_state;

    int cyc = 0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        int         cyc;
        logic       em;
        int         ecnt;
        logic [1:0] est;
        logic       sm;
        int         scnt;
        logic [1:0] sst;
    } exp_t;

    exp_t q[$];

    seq_detector #(.W(2), .LEN(3), .CNT_W(8)) u_main (
        .clk_i       (clk),
        .rst_i       (rst),
        .in_valid_i  (vld),
        .in_sym_i    (sym),
        .pat_i       (pat),
        .overlap_i   (ovl),
        .clr_i       (clr),
        .match_o     (m_match),
        .match_cnt_o (m_cnt),
        .state_o     (m_state)
    );

    seq_detector #(.W(2), .LEN(3), .CNT_W(2)) u_sat (
        .clk_i       (clk),
        .rst_i       (rst_sat),
        .in_valid_i  (vld),
        .in_sym_i    (sym),
        .pat_i       (pat),
        .overlap_i   (ovl),
        .clr_i       (clr),
        .match_o     (s_match),
        .match_cnt_o (s_cnt),
        .state_o     (s_state)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int c, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s @cycle %0d: got %0d, expected %0d", name, c, act, exp);
        end
    endtask

    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            exp_t e;
            e = q.pop_front();
            chk("main.match", e.cyc, int'(m_match), int'(e.em));
            chk("main.match_cnt", e.cyc, int'(m_cnt), e.ecnt);
            chk("main.state", e.cyc, int'(m_state), int'(e.est));
            chk("sat.match", e.cyc, int'(s_match), int'(e.sm));
            chk("sat.match_cnt", e.cyc, int'(s_cnt), e.scnt);
            chk("sat.state", e.cyc, int'(s_state), int'(e.sst));
        end
    end

    task automatic drive(input logic r, input logic rs, input logic c, input logic vl,
                         input logic [1:0] s, input logic em, input int ec, input logic [1:0] es,
                         input logic sm, input int sc, input logic [1:0] ss);
        exp_t e;
        rst = r;
        rst_sat = rs;
        clr = c;
        vld = vl;
        sym = s;
        e.cyc = cyc + 1;
        e.em = em;
        e.ecnt = ec;
        e.est = es;
        e.sm = sm;
        e.scnt = sc;
        e.sst = ss;
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic step(input logic c, input logic vl, input logic [1:0] s,
                        input logic em, input int ec, input logic [1:0] es);
        drive(1'b0, 1'b1, c, vl, s, em, ec, es, 1'b0, 0, E);
    endtask

    task automatic sstep(input logic vl, input logic [1:0] s,
                         input logic sm, input int sc, input logic [1:0] ss);
        drive(1'b1, 1'b0, 1'b0, vl, s, 1'b0, 0, E, sm, sc, ss);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        @(posedge clk);
        #1;

        // reset with random inputs, then 1,2,3
        pat = PAT_123; ovl = 1'b1;
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'b1, 1'($urandom), 1'($urandom), 2'($urandom), 1'b0, 0, E, 1'b0, 0, E);
        end
        step(0, 1, 2'd1, 0, 0, F);
        step(0, 1, 2'd2, 0, 0, A);
        step(0, 1, 2'd3, 1, 1, A);
        step(0, 0, 2'd0, 0, 1, A);

        // gaps
        step(1, 0, 2'd0, 0, 0, E);
        step(0, 1, 2'd1, 0, 0, F);
        for (int i = 0; i < 3; i++) step(0, 0, 2'd2, 0, 0, F);
        step(0, 1, 2'd2, 0, 0, A);
        step(0, 0, 2'd3, 0, 0, A);
        step(0, 1, 2'd3, 1, 1, A);
        step(0, 0, 2'd0, 0, 1, A);

        // overlapping detection on constant pattern
        pat = PAT_111; ovl = 1'b1;
        step(1, 0, 2'd0, 0, 0, E);
        step(0, 1, 2'd1, 0, 0, F);
        step(0, 1, 2'd1, 0, 0, A);
        step(0, 1, 2'd1, 1, 1, A);
        step(0, 1, 2'd1, 1, 2, A);
        step(0, 1, 2'd1, 1, 3, A);
        step(0, 0, 2'd0, 0, 3, A);

        // non-overlapping detection
        ovl = 1'b0;
        step(1, 0, 2'd0, 0, 0, E);
        step(0, 1, 2'd1, 0, 0, F);
        step(0, 1, 2'd1, 0, 0, A);
        step(0, 1, 2'd1, 1, 1, E);
        step(0, 1, 2'd1, 0, 1, F);
        step(0, 1, 2'd1, 0, 1, A);
        step(0, 0, 2'd0, 0, 1, A);

        // clr beats a simultaneous accept; history kept but fill restarts
        pat = PAT_123; ovl = 1'b1;
        step(0, 1, 2'd1, 0, 1, A);
        step(0, 1, 2'd2, 0, 1, A);
        step(1, 1, 2'd3, 0, 0, E);
        step(0, 1, 2'd2, 0, 0, F);
        step(0, 1, 2'd3, 0, 0, A);
        step(0, 0, 2'd0, 0, 0, A);

        // rst together with clr returns reset values after a match
        step(0, 1, 2'd1, 0, 0, A);
        step(0, 1, 2'd2, 0, 0, A);
        step(0, 1, 2'd3, 1, 1, A);
        drive(1'b1, 1'b1, 1'b1, 1'b1, 2'd3, 1'b0, 0, E, 1'b0, 0, E);

        // partial matches then a single hit
        step(0, 1, 2'd1, 0, 0, F);
        step(0, 1, 2'd2, 0, 0, A);
        step(0, 1, 2'd2, 0, 0, A);
        step(0, 1, 2'd1, 0, 0, A);
        step(0, 1, 2'd2, 0, 0, A);
        step(0, 1, 2'd3, 1, 1, A);
        step(0, 0, 2'd0, 0, 1, A);

        // 2-bit counter saturation on the second instance
        pat = PAT_111; ovl = 1'b1;
        sstep(1, 2'd1, 0, 0, F);
        sstep(1, 2'd1, 0, 0, A);
        sstep(1, 2'd1, 1, 1, A);
        sstep(1, 2'd1, 1, 2, A);
        sstep(1, 2'd1, 1, 3, A);
        sstep(1, 2'd1, 1, 3, A);
        sstep(1, 2'd1, 1, 3, A);
        sstep(0, 2'd0, 0, 3, A);

        vld = 1'b0;
        for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
        #1;
        if (q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_detector.md
# seq_detector

Parametrised, streaming symbol-sequence detector: accepts one W-bit symbol per valid cycle, raises a one-cycle registered `match` pulse when the last LEN accepted symbols equal a run-time programmable pattern, and keeps a saturating match counter. It supports overlapping and non-overlapping detection and tolerates gaps in the input stream. It is the generalised successor of the lab's two-input (a, b) single-output FSM detectors, and sits between a symbol source and any control logic that reacts to detected sequences.

## Interface
- `W`, 2, symbol width in bits. W=2 covers the legacy a/b input pair.
- `LEN`, 4, pattern length in symbols; legal range 2..16.
- `CNT_W`, 8, width of the match counter.

- `clk` in 1: the single clock; all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: the `in_sym` symbol is accepted this cycle.
- `in_sym` in W: input symbol.
- `pat` in LEN*W: pattern; symbol k at `pat[k*W +: W]`, k=0 oldest, k=LEN-1 newest.
- `overlap` in 1: 1 = overlapping detection, 0 = non-overlapping.
- `clr` in 1: synchronous soft clear of history fill, counter and match.
- `match` out 1: registered one-cycle pulse per detection.
- `match_cnt` out CNT_W: saturating count of detections.
- `state` out 2: current FSM state (debug/observability).

## Operation
- History: LEN-1 most recent accepted symbols `hist[0..LEN-2]` (0 oldest), plus `fill` counter 0..LEN-1, saturating.
- FSM (derived from `fill`): EMPTY (fill=0), FILLING (0<fill<LEN-1), ARMED (fill=LEN-1).
- On accept (`in_valid`=1, `clr`=0): shift `in_sym` into history; `fill` increments, saturating at LEN-1.
- Hit condition: accept in ARMED and {hist[0..LEN-2], in_sym} == `pat`, element-wise.
- `pat` and `overlap` are sampled at the accepting edge; changes take effect on the next accept, and history is not discarded.
- On a hit:
  - `match` is 1 next cycle.
  - `match_cnt` increments, saturating at 2^CNT_W-1 (never wraps).
  - if `overlap`=0, `fill` is set to 0 (state EMPTY); the next hit needs LEN fresh symbols.
  - if `overlap`=1, `fill` stays LEN-1.
- Cycles with `in_valid`=0: history, fill and counter hold; `match` is 0.
- `clr`: next cycle fill=0, `match`=0, `match_cnt`=0. History contents are don't-care. `clr` wins over a simultaneous `in_valid`, and that symbol is dropped.
- `rst`: same effect as `clr`, and additionally zeroes history. `rst` dominates `clr`. Reset mid-stream discards any partial match.

## Timing
- Reset values: `match`=0, `match_cnt`=0, `state`=EMPTY, fill=0, history=0.
- Latency: `match` is high in the cycle after the edge that accepted the final pattern symbol.
- Maximum detection rate: one `match` per cycle (overlap=1, e.g. constant pattern).
- `match_cnt` updates on the same edge that raises `match`.
- No combinational path from inputs to outputs; all outputs are registered.

## Structure
- Package `seq_det_pkg`:
  - state typedef `seq_state_t` {EMPTY, FILLING, ARMED}, 2 bits;
  - function computing the `fill` width, `$clog2(LEN)`.
- Sub-module `sym_shift_reg` (W, DEPTH=LEN-1): enable-shifted history register with synchronous clear, exposing all stages flattened.
- Top level: fill/FSM, comparator, saturating counter, output registers.

## Test plan
All scenarios use W=2, LEN=3 and pat = {2'd3, 2'd2, 2'd1} (oldest=1, then 2, newest=3) unless noted.
- Reset: hold `rst` for 2 cycles with random inputs -> match=0, match_cnt=0, state=EMPTY. Then stream 1,2,3 -> match high exactly one cycle after the 3rd accept; match_cnt=1.
- Gaps: stream 1, idle×3, 2, idle, 3 -> exactly one match, one cycle after the 3; no match during idles.
- Overlap with pat=1,1,1 and stream 1,1,1,1,1:
  - overlap=1 -> matches after the 3rd, 4th and 5th symbols; match_cnt=3;
  - overlap=0 -> a single match after the 3rd symbol; match_cnt=1.
- Saturation: CNT_W=2, pat=1,1,1, overlap=1, seven 1s -> 5 matches; match_cnt saturates at 3 and stays at 3.
- Clear/priority:
  - stream 1,2, then 3 with `clr`=1 in the same cycle -> no match, fill=0;
  - stream 2,3 -> no match;
  - `rst` and `clr` together -> reset values.
- Mismatch/partial: stream 1,2,2,1,2,3 -> a single match after the final 3; state sequence EMPTY, FILLING, ARMED, ARMED....
